// File: rtl/dmem_mmio_unit.sv
// Data-side memory unit: word-organised RAM with byte/half lanes and load extension,
// plus a 16-byte MMIO window (LED, synchronised switches, cycle counter, countdown timer).
module dmem_mmio_unit #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic [2:0]  dm_type,
  output logic [31:0] dout,
  output logic        acc_err,
  output logic        err_sticky,
  output logic [15:0] led_out,
  input  logic [15:0] sw_in,
  output logic        timer_irq
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic          mmio_hit;
  logic          misalign;
  logic          illegal;
  logic          wr_ok;
  logic          ram_wr;
  logic          led_wr;
  logic          tmr_wr;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [31:0]   ram_rd;
  logic [31:0]   mmio_rd;
  logic [15:0]   sw_sync1;
  logic [15:0]   sw_sync2;
  logic [31:0]   cycle_cnt;
  logic [31:0]   timer;

  // Right-justify the addressed lane(s) and extend according to the access type.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  ofs,
                                              input logic [2:0]  kind);
    logic        [31:0] sh;
    logic signed [15:0] h;
    logic signed [7:0]  b;
    logic signed [31:0] r;
    sh = word >> {ofs, 3'b000};
    h  = sh[15:0];
    b  = sh[7:0];
    case (kind)
      3'b001:  r = h;
      3'b010:  r = {16'b0, sh[15:0]};
      3'b011:  r = b;
      3'b100:  r = {24'b0, sh[7:0]};
      default: r = word;
    endcase
    return r;
  endfunction

  assign idx      = addr[AW+1:2];
  assign mmio_hit = (addr[31:4] == MMIO_BASE[31:4]);

  always_comb begin
    misalign = 1'b0;
    illegal  = 1'b0;
    case (dm_type)
      3'b000:         misalign = (addr[1:0] != 2'b00);
      3'b001, 3'b010: misalign = addr[0];
      3'b011, 3'b100: misalign = 1'b0;
      default:        illegal  = 1'b1;
    endcase
    if (mmio_hit && dm_type != 3'b000) illegal = 1'b1;
  end

  assign acc_err = misalign | illegal;
  assign wr_ok   = mem_w & ~acc_err;
  assign ram_wr  = wr_ok & ~mmio_hit;
  assign led_wr  = wr_ok & mmio_hit & (addr[3:2] == 2'd0);
  assign tmr_wr  = wr_ok & mmio_hit & (addr[3:2] == 2'd3);

  // Replicate store data across lanes so the byte enables alone pick the target.
  always_comb begin
    be    = 4'b0000;
    wdata = din;
    case (dm_type)
      3'b000: be = 4'b1111;
      3'b001, 3'b010: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{din[15:0]}};
      end
      3'b011, 3'b100: begin
        be    = 4'b0001 << addr[1:0];
        wdata = {4{din[7:0]}};
      end
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (ram_wr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign ram_rd = load_extend(mem[idx], addr[1:0], dm_type);

  always_comb begin
    case (addr[3:2])
      2'd0:    mmio_rd = {16'b0, led_out};
      2'd1:    mmio_rd = {16'b0, sw_sync2};
      2'd2:    mmio_rd = cycle_cnt;
      default: mmio_rd = timer;
    endcase
  end

  assign dout = acc_err ? 32'd0 : (mmio_hit ? mmio_rd : ram_rd);

  // A timer write wins over the expiry of the old value in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_out    <= '0;
      sw_sync1   <= '0;
      sw_sync2   <= '0;
      cycle_cnt  <= '0;
      timer      <= '0;
      timer_irq  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      sw_sync1   <= sw_in;
      sw_sync2   <= sw_sync1;
      cycle_cnt  <= cycle_cnt + 32'd1;
      err_sticky <= err_sticky | acc_err;
      if (led_wr) led_out <= din[15:0];
      if (tmr_wr) begin
        timer     <= din;
        timer_irq <= 1'b0;
      end else if (timer != 32'd0) begin
        timer     <= timer - 32'd1;
        timer_irq <= (timer == 32'd1);
      end else begin
        timer_irq <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_mmio_unit.sv
// Scoreboard bench for dmem_mmio_unit: a byte-addressed reference model predicts each
// cycle's outputs; a negedge monitor pops and compares them against the DUT.
module tb_dmem_mmio_unit;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'hFFFF0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_w;
  logic [31:0] addr;
  logic [31:0] din;
  logic [2:0]  dm_type;
  logic [31:0] dout;
  logic        acc_err;
  logic        err_sticky;
  logic [15:0] led_out;
  logic [15:0] sw_in;
  logic        timer_irq;

  dmem_mmio_unit #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(BASE)) dut (
    .clk(clk), .reset(reset), .mem_w(mem_w), .addr(addr), .din(din),
    .dm_type(dm_type), .dout(dout), .acc_err(acc_err), .err_sticky(err_sticky),
    .led_out(led_out), .sw_in(sw_in), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          skip;
    logic [31:0] dout;
    logic        err;
    logic [15:0] led;
    logic        sticky;
    logic        irq;
    bit          hk;
    logic [31:0] k;
    int          tag;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 0;
  bit   drained  = 0;

  // Reference model state
  logic [7:0]  mb [DEPTH*4];
  logic [15:0] m_led, m_s1, m_s2, sw_val;
  logic [31:0] m_cyc, m_tmr;
  logic        m_irq, m_sticky;
  bit          m_known = 0;

  function automatic void cmp(input int tag, input string nm,
                              input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s tag=%0d got=%h want=%h t=%0t", nm, tag, act, req, $time);
    end
  endfunction

  task automatic step(input logic rst, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [2:0] t,
                      input bit hk, input logic [31:0] k, input int tag);
    exp_t        e;
    int          size, ba, off;
    bit          mmio, err;
    logic [31:0] v;
    @(posedge clk);
    #1;
    reset = rst; mem_w = w; addr = a; din = d; dm_type = t; sw_in = sw_val;
    mmio = ((a >> 4) == (BASE >> 4));
    if (t == 3'd0) size = 4;
    else if (t == 3'd1 || t == 3'd2) size = 2;
    else if (t == 3'd3 || t == 3'd4) size = 1;
    else size = 0;
    err = 0;
    if (size == 0) err = 1;
    else if ((a % size) != 0) err = 1;
    if (mmio && t != 3'd0) err = 1;
    off = int'(a & 32'hF);
    ba  = int'(a % (DEPTH*4));
    v = 32'd0;
    if (!err) begin
      if (mmio) begin
        case (off)
          0:  v = {16'h0, m_led};
          4:  v = {16'h0, m_s2};
          8:  v = m_cyc;
          default: v = m_tmr;
        endcase
      end else begin
        for (int i = 0; i < size; i++) v = v | (32'(mb[ba+i]) << (8*i));
        if (t == 3'd1 && v[15]) v = v | 32'hFFFF0000;
        if (t == 3'd3 && v[7])  v = v | 32'hFFFFFF00;
      end
    end
    e.skip = !m_known; e.dout = v; e.err = err; e.led = m_led; e.sticky = m_sticky;
    e.irq = m_irq; e.hk = hk; e.k = k; e.tag = tag;
    q.push_back(e);
    // State as it will be after the coming clock edge
    if (rst) begin
      foreach (mb[i]) mb[i] = 8'h00;
      m_led = 0; m_s1 = 0; m_s2 = 0; m_cyc = 0; m_tmr = 0; m_irq = 0; m_sticky = 0;
      m_known = 1;
    end else begin
      m_sticky = m_sticky | err;
      m_s2 = m_s1; m_s1 = sw_val;
      m_cyc = m_cyc + 1;
      if (w && !err && mmio && off == 12) begin
        m_tmr = d; m_irq = 0;
      end else if (m_tmr != 0) begin
        m_irq = (m_tmr == 1); m_tmr = m_tmr - 1;
      end else begin
        m_irq = 0;
      end
      if (w && !err) begin
        if (mmio) begin
          if (off == 0) m_led = d[15:0];
        end else begin
          for (int i = 0; i < size; i++) mb[ba+i] = 8'(d >> (8*i));
        end
      end
    end
  endtask

  task automatic idle();
    step(0, 0, 32'h0, 32'h0, 3'd0, 0, 32'h0, 0);
  endtask
  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    step(0, 1, a, d, t, 0, 32'h0, 0);
  endtask
  task automatic ldk(input logic [31:0] a, input logic [2:0] t, input logic [31:0] k, input int tag);
    step(0, 0, a, 32'h0, t, 1, k, tag);
  endtask

  exp_t me;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      if (!me.skip) begin
        cmp(me.tag, "dout",       dout,                 me.dout);
        cmp(me.tag, "acc_err",    {31'b0, acc_err},     {31'b0, me.err});
        cmp(me.tag, "led_out",    {16'b0, led_out},     {16'b0, me.led});
        cmp(me.tag, "err_sticky", {31'b0, err_sticky},  {31'b0, me.sticky});
        cmp(me.tag, "timer_irq",  {31'b0, timer_irq},   {31'b0, me.irq});
        if (me.hk) cmp(me.tag, "dout_plan", dout, me.k);
      end
    end
    if (done && !drained) begin
      drained = 1;
      checks++;
      if (q.size() != 0) begin
        failures++;
        $display("FAIL drain pending=%0d want=0", q.size());
      end
    end
  end

  initial begin
    int          sel;
    logic [31:0] a, d;
    logic [2:0]  t;
    logic        w, r;
    reset = 1; mem_w = 0; addr = 0; din = 0; dm_type = 0; sw_in = 0; sw_val = 0;
    step(1, 0, 32'h0, 32'h0, 3'd0, 0, 32'h0, 0);

    // Cycle counter after reset release
    repeat (9) idle();
    ldk(BASE + 8, 3'd0, 32'd9, 60);
    ldk(BASE + 8, 3'd0, 32'd10, 61);
    st(BASE + 8, 32'h12345678, 3'd0);
    ldk(BASE + 8, 3'd0, 32'd12, 62);

    // Lanes and extension
    st(32'h10, 32'h11223344, 3'd0);
    st(32'h11, 32'h000000AB, 3'd3);
    st(32'h12, 32'h0000BEEF, 3'd1);
    ldk(32'h10, 3'd0, 32'hBEEFAB44, 10);
    ldk(32'h11, 3'd3, 32'hFFFFFFAB, 11);
    ldk(32'h11, 3'd4, 32'h000000AB, 12);
    ldk(32'h12, 3'd1, 32'hFFFFBEEF, 13);
    ldk(32'h12, 3'd2, 32'h0000BEEF, 14);

    // Misaligned accesses
    st(32'h21, 32'hDEADBEEF, 3'd0);
    ldk(32'h20, 3'd0, 32'h0, 20);
    ldk(32'h23, 3'd1, 32'h0, 21);
    ldk(32'h20, 3'd5, 32'h0, 22);

    // Aliasing, then reset clears RAM and err_sticky
    st(32'h1000, 32'h5A5A5A5A, 3'd0);
    ldk(32'h0, 3'd0, 32'h5A5A5A5A, 30);
    step(1, 0, 32'h0, 32'h0, 3'd0, 0, 32'h0, 0);
    ldk(32'h0, 3'd0, 32'h0, 31);

    // LED and switch synchroniser
    st(BASE, 32'h0001F0F0, 3'd0);
    sw_val = 16'h1234;
    ldk(BASE + 4, 3'd0, 32'h0, 40);
    ldk(BASE + 4, 3'd0, 32'h0, 41);
    ldk(BASE + 4, 3'd0, 32'h00001234, 42);
    st(BASE, 32'h00005555, 3'd1);
    ldk(BASE, 3'd0, 32'h0000F0F0, 43);

    // Timer countdown, expiry, and rewrite while at 1
    st(BASE + 12, 32'd3, 3'd0);
    ldk(BASE + 12, 3'd0, 32'd3, 50);
    ldk(BASE + 12, 3'd0, 32'd2, 51);
    ldk(BASE + 12, 3'd0, 32'd1, 52);
    ldk(BASE + 12, 3'd0, 32'd0, 53);
    ldk(BASE + 12, 3'd0, 32'd0, 54);
    st(BASE + 12, 32'd3, 3'd0);
    ldk(BASE + 12, 3'd0, 32'd3, 55);
    ldk(BASE + 12, 3'd0, 32'd2, 56);
    st(BASE + 12, 32'd5, 3'd0);
    ldk(BASE + 12, 3'd0, 32'd5, 57);
    ldk(BASE + 12, 3'd0, 32'd4, 58);
    st(BASE + 12, 32'd0, 3'd0);
    ldk(BASE + 12, 3'd0, 32'd0, 59);

    // Randomised traffic
    for (int n = 0; n < 800; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6) a = $urandom_range(0, 63);
      else if (sel == 6) a = 32'h1000 * $urandom_range(1, 15) + $urandom_range(0, 63);
      else a = BASE + $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) t = 3'($urandom_range(0, 7));
      else if (sel >= 7) t = 3'd0;
      else t = 3'($urandom_range(0, 4));
      d = (sel >= 7) ? $urandom_range(0, 6) : $urandom;
      w = ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 7) == 0) sw_val = 16'($urandom);
      step(r, w, a, d, t, 0, 32'h0, 1000 + n);
    end

    idle();
    done = 1;
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
